// File: rtl/sram6116_arb.sv
`default_nettype none
// ============================================================================
// Module   : sram6116_arb
// Purpose  : Two-port arbiter and access sequencer for the 6116 SRAM stage.
//            A CPU port (read/write) and a video port (read-only) raise
//            level-held requests. Video has priority, but a burst counter
//            limits how many video grants in a row may pass a waiting CPU
//            request. All SRAM strobes, address and write data are
//            registered. Read data comes from the 6116 stage's registered
//            Dout and is returned with a one-cycle ack pulse.
//
// Ports    : phi0              system clock, rising edge
//            rst_b             asynchronous active-low reset
//            cpu_req/we/addr/wdata -> cpu_ack, cpu_rdata
//            vid_req/addr          -> vid_ack, vid_rdata
//            A, Din, CS_b, WE_b, OE_b  registered SRAM-side outputs
//            Dout              registered SRAM read data
//            wr_viol           sticky write-protect violation flag
//
// Options  : SRAM_ARB_WRPROT_EN  when defined, CPU writes at or above
//            PROT_BASE are suppressed at the SRAM and set wr_viol.
//
// Revision : 1.0  initial release
// ============================================================================
module sram6116_arb #(
    parameter int                ADDR_W    = 11,
    parameter int                DATA_W    = 8,
    parameter int                VID_BURST = 4,
    parameter logic [ADDR_W-1:0] PROT_BASE = ADDR_W'('h700)
) (
    input  logic              phi0,
    input  logic              rst_b,
    // CPU port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    // Video port
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    // 6116 stage
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] Din,
    input  logic [DATA_W-1:0] Dout,
    output logic              CS_b,
    output logic              WE_b,
    output logic              OE_b,
    // Status
    output logic              wr_viol
);

    localparam int                 c_RUN_W   = $clog2(VID_BURST + 1);
    localparam logic [c_RUN_W-1:0] c_RUN_MAX = c_RUN_W'(VID_BURST);

`ifdef SRAM_ARB_WRPROT_EN
    localparam logic c_WRPROT_EN = 1'b1;
`else
    localparam logic c_WRPROT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_RCAP = 3'd2,
        ST_WR   = 3'd3,
        ST_ACK  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [c_RUN_W-1:0]  r_vid_run;
    logic                r_gnt_vid;     // 1 = current read belongs to video
    logic [ADDR_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_din;
    logic                r_cs_b;
    logic                r_we_b;
    logic                r_oe_b;
    logic                r_cpu_ack;
    logic                r_vid_ack;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_vid_rdata;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t              w_state_nxt;
    logic [c_RUN_W-1:0]  w_vid_run_nxt;
    logic                w_gnt_vid_nxt;
    logic [ADDR_W-1:0]   w_a_nxt;
    logic [DATA_W-1:0]   w_din_nxt;
    logic                w_cs_b_nxt;
    logic                w_we_b_nxt;
    logic                w_oe_b_nxt;
    logic                w_cpu_ack_nxt;
    logic                w_vid_ack_nxt;
    logic [DATA_W-1:0]   w_cpu_rdata_nxt;
    logic [DATA_W-1:0]   w_vid_rdata_nxt;

    // Arbitration decision, only meaningful in IDLE. Video wins unless it
    // has used up its burst allowance while the CPU is waiting.
    logic w_vid_win;
    logic w_cpu_win;
    logic w_prot;

    assign w_vid_win = vid_req && ((r_vid_run < c_RUN_MAX) || !cpu_req);
    assign w_cpu_win = !w_vid_win && cpu_req;

    // Constant-folds to 0 when write protection is not built in.
    assign w_prot = c_WRPROT_EN && (cpu_addr >= PROT_BASE);

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_vid_run_nxt   = r_vid_run;
        w_gnt_vid_nxt   = r_gnt_vid;
        w_a_nxt         = r_a;
        w_din_nxt       = r_din;
        w_cs_b_nxt      = 1'b1;
        w_we_b_nxt      = 1'b1;
        w_oe_b_nxt      = 1'b1;
        w_cpu_ack_nxt   = 1'b0;
        w_vid_ack_nxt   = 1'b0;
        w_cpu_rdata_nxt = r_cpu_rdata;
        w_vid_rdata_nxt = r_vid_rdata;

        case (r_state)
            ST_IDLE: begin
                if (w_vid_win) begin
                    w_state_nxt   = ST_RD;
                    w_gnt_vid_nxt = 1'b1;
                    w_a_nxt       = vid_addr;
                    w_cs_b_nxt    = 1'b0;
                    w_oe_b_nxt    = 1'b0;
                    // Only grants that pass a waiting CPU count toward
                    // the burst limit.
                    if (!cpu_req) begin
                        w_vid_run_nxt = '0;
                    end else if (r_vid_run != c_RUN_MAX) begin
                        w_vid_run_nxt = r_vid_run + c_RUN_W'(1);
                    end
                end else if (w_cpu_win) begin
                    w_gnt_vid_nxt = 1'b0;
                    w_vid_run_nxt = '0;
                    w_a_nxt       = cpu_addr;
                    if (cpu_we) begin
                        w_state_nxt = ST_WR;
                        w_din_nxt   = cpu_wdata;
                        // A protected write keeps its timing and ack but
                        // never touches the array.
                        if (!w_prot) begin
                            w_cs_b_nxt = 1'b0;
                            w_we_b_nxt = 1'b0;
                        end
                    end else begin
                        w_state_nxt = ST_RD;
                        w_cs_b_nxt  = 1'b0;
                        w_oe_b_nxt  = 1'b0;
                    end
                end
            end

            // Strobes were active for this cycle; the 6116 stage registers
            // its data at the end of it, so nothing to capture yet.
            ST_RD: begin
                w_state_nxt = ST_RCAP;
            end

            // Dout is valid throughout this cycle; latch it at its end.
            ST_RCAP: begin
                w_state_nxt = ST_ACK;
                if (r_gnt_vid) begin
                    w_vid_rdata_nxt = Dout;
                    w_vid_ack_nxt   = 1'b1;
                end else begin
                    w_cpu_rdata_nxt = Dout;
                    w_cpu_ack_nxt   = 1'b1;
                end
            end

            ST_WR: begin
                w_state_nxt   = ST_ACK;
                w_cpu_ack_nxt = 1'b1;
            end

            // Ack cycle: the requester sees its pulse here and may drop or
            // keep its request before the next IDLE sample.
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register. The asynchronous reset releases the strobes at once
    // and abandons any transaction in flight without an ack.
    // ------------------------------------------------------------------
    always_ff @(posedge phi0 or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= ST_IDLE;
            r_vid_run   <= '0;
            r_gnt_vid   <= 1'b0;
            r_a         <= '0;
            r_din       <= '0;
            r_cs_b      <= 1'b1;
            r_we_b      <= 1'b1;
            r_oe_b      <= 1'b1;
            r_cpu_ack   <= 1'b0;
            r_vid_ack   <= 1'b0;
            r_cpu_rdata <= '0;
            r_vid_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_vid_run   <= w_vid_run_nxt;
            r_gnt_vid   <= w_gnt_vid_nxt;
            r_a         <= w_a_nxt;
            r_din       <= w_din_nxt;
            r_cs_b      <= w_cs_b_nxt;
            r_we_b      <= w_we_b_nxt;
            r_oe_b      <= w_oe_b_nxt;
            r_cpu_ack   <= w_cpu_ack_nxt;
            r_vid_ack   <= w_vid_ack_nxt;
            r_cpu_rdata <= w_cpu_rdata_nxt;
            r_vid_rdata <= w_vid_rdata_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Write-protect violation flag
    // ------------------------------------------------------------------
`ifdef SRAM_ARB_WRPROT_EN
    logic r_wr_viol;
    logic w_viol_set;

    assign w_viol_set = (r_state == ST_IDLE) && w_cpu_win && cpu_we && w_prot;

    always_ff @(posedge phi0 or negedge rst_b) begin
        if (!rst_b) begin
            r_wr_viol <= 1'b0;
        end else if (w_viol_set) begin
            r_wr_viol <= 1'b1;
        end
    end

    assign wr_viol = r_wr_viol;
`else
    assign wr_viol = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign A         = r_a;
    assign Din       = r_din;
    assign CS_b      = r_cs_b;
    assign WE_b      = r_we_b;
    assign OE_b      = r_oe_b;
    assign cpu_ack   = r_cpu_ack;
    assign vid_ack   = r_vid_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign vid_rdata = r_vid_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram6116_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram6116_arb
// Purpose  : Self-checking bench for sram6116_arb. A small 6116 model with
//            registered Dout sits behind the DUT. Directed tasks push the
//            expected ack (port, read data) into a queue when they issue a
//            request; a monitor pops and compares on every ack.
// Revision : 1.0  initial release
// ============================================================================
module tb_sram6116_arb;

    logic        phi0 = 1'b0;
    logic        rst_b = 1'b0;
    logic        cpu_req, cpu_we, vid_req;
    logic [10:0] cpu_addr, vid_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack, vid_ack;
    logic [7:0]  cpu_rdata, vid_rdata;
    logic [10:0] A;
    logic [7:0]  Din, Dout;
    logic        CS_b, WE_b, OE_b, wr_viol;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_low = 0;

    always #5 phi0 = ~phi0;

    sram6116_arb dut (
        .phi0(phi0), .rst_b(rst_b),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_rdata(vid_rdata),
        .A(A), .Din(Din), .Dout(Dout),
        .CS_b(CS_b), .WE_b(WE_b), .OE_b(OE_b), .wr_viol(wr_viol)
    );

    // ---------------- 6116 stage model ----------------
    logic [7:0]  mem [0:2047];
    logic [7:0]  dout_q = 8'h00;
    logic        dout_en = 1'b0;
    logic        pl_en = 1'b0;
    logic [10:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    always @(posedge phi0) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (!CS_b && !WE_b) mem[A] <= Din;
        dout_en <= !CS_b && !OE_b;
        dout_q  <= mem[A];
    end
    // 8'hEE stands in for an undriven bus: a mistimed capture picks it up.
    assign Dout = dout_en ? dout_q : 8'hEE;

    initial forever begin @(posedge phi0); cyc++; end
    initial forever begin @(negedge phi0); if (!WE_b) we_low++; end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic       is_vid;
        logic       is_rd;
        logic [7:0] data;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic push_exp(input logic v, input logic rd, input logic [7:0] d);
        exp_t e;
        e.is_vid = v; e.is_rd = rd; e.data = d;
        sb_q.push_back(e);
    endtask

    initial begin
        logic prev_c, prev_v;
        exp_t e;
        prev_c = 1'b0; prev_v = 1'b0;
        forever begin
            @(negedge phi0);
            if (cpu_ack || vid_ack) begin
                chk("ack_single_cycle", 32'({prev_c & cpu_ack, prev_v & vid_ack}), 32'd0);
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack actual cpu_ack=%0b vid_ack=%0b required none", cpu_ack, vid_ack);
                end else begin
                    e = sb_q.pop_front();
                    chk("ack_port", 32'({cpu_ack, vid_ack}), 32'({~e.is_vid, e.is_vid}));
                    if (e.is_rd) begin
                        if (e.is_vid) chk("vid_rdata", 32'(vid_rdata), 32'(e.data));
                        else          chk("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
                    end
                end
            end
            prev_c = cpu_ack; prev_v = vid_ack;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic preload(input logic [10:0] a, input logic [7:0] d);
        @(negedge phi0); pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge phi0); pl_en = 1'b0;
    endtask

    // Latency is counted in falling edges from request assertion to the
    // first falling edge that sees ack: 3 for a read, 2 for a write.
    task automatic cpu_txn(input logic we, input logic [10:0] a, input logic [7:0] wd,
                           input logic [7:0] exp_rd, input int exp_lat, input string nm);
        int  lat;
        bit  done;
        @(negedge phi0);
        push_exp(1'b0, ~we, exp_rd);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        lat = 0; done = 0;
        while (!done && lat < 20) begin
            @(negedge phi0); lat++;
            if (cpu_ack) done = 1;
        end
        cpu_req = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual no cpu_ack required ack", nm);
        end else chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic vid_txn(input logic [10:0] a, input logic [7:0] exp_rd, input string nm);
        int  lat;
        bit  done;
        @(negedge phi0);
        push_exp(1'b1, 1'b1, exp_rd);
        vid_req = 1'b1; vid_addr = a;
        lat = 0; done = 0;
        while (!done && lat < 20) begin
            @(negedge phi0); lat++;
            if (vid_ack) done = 1;
        end
        vid_req = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual no vid_ack required ack", nm);
        end else chk({nm, "_latency"}, 32'(lat), 32'd3);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_strobes"}, 32'({CS_b, WE_b, OE_b}), 32'b111);
        chk({nm, "_a_din"}, 32'({A, Din}), 32'd0);
        chk({nm, "_acks_rdata"}, 32'({cpu_ack, vid_ack, cpu_rdata, vid_rdata, wr_viol}), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w0, n, budget;
        int t[3];
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 0; vid_addr = '0;

        // Reset state
        repeat (3) @(negedge phi0);
        chk_reset_vals("reset");
        rst_b = 1'b1;
        repeat (2) @(negedge phi0);
        chk("idle_strobes", 32'({CS_b, WE_b, OE_b}), 32'b111);

        // CPU write 0x5A -> 0x123, then read it back
        w0 = we_low;
        cpu_txn(1'b1, 11'h123, 8'h5A, 8'h00, 2, "cpu_wr");
        chk("we_low_cycles", 32'(we_low - w0), 32'd1);
        cpu_txn(1'b0, 11'h123, 8'h00, 8'h5A, 3, "cpu_rd");

        // Video read of top address; CPU side untouched
        preload(11'h7FF, 8'hC3);
        vid_txn(11'h7FF, 8'hC3, "vid_rd");
        chk("cpu_rdata_hold", 32'(cpu_rdata), 32'h5A);

        // Both requests held: V,V,V,V,C,V,V,V,V,C
        preload(11'h010, 8'h11);
        preload(11'h020, 8'h22);
        @(negedge phi0);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) push_exp(1'b1, 1'b1, 8'h11);
            push_exp(1'b0, 1'b1, 8'h22);
        end
        vid_req = 1'b1; vid_addr = 11'h010;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h020;
        n = 0; budget = 0;
        while (n < 10 && budget < 200) begin
            @(negedge phi0); budget++;
            if (cpu_ack || vid_ack) n++;
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        chk("arb_ack_count", 32'(n), 32'd10);

        // Back-to-back CPU reads, request held
        @(negedge phi0);
        for (int k = 0; k < 3; k++) push_exp(1'b0, 1'b1, 8'h22);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h020;
        n = 0; budget = 0;
        while (n < 3 && budget < 100) begin
            @(negedge phi0); budget++;
            if (cpu_ack) begin t[n] = cyc; n++; end
        end
        cpu_req = 1'b0;
        chk("b2b_ack_count", 32'(n), 32'd3);
        if (n == 3) begin
            chk("b2b_spacing_0", 32'(t[1] - t[0]), 32'd4);
            chk("b2b_spacing_1", 32'(t[2] - t[1]), 32'd4);
        end

        // Write to the protected region
        preload(11'h700, 8'h3C);
        w0 = we_low;
        cpu_txn(1'b1, 11'h700, 8'hFF, 8'h00, 2, "prot_wr");
`ifdef SRAM_ARB_WRPROT_EN
        chk("prot_we_low_cycles", 32'(we_low - w0), 32'd0);
        chk("prot_wr_viol", 32'(wr_viol), 32'd1);
        cpu_txn(1'b0, 11'h700, 8'h00, 8'h3C, 3, "prot_rd");
        chk("prot_wr_viol_sticky", 32'(wr_viol), 32'd1);
`else
        chk("prot_we_low_cycles", 32'(we_low - w0), 32'd1);
        chk("prot_wr_viol", 32'(wr_viol), 32'd0);
        cpu_txn(1'b0, 11'h700, 8'h00, 8'hFF, 3, "prot_rd");
        chk("prot_wr_viol_sticky", 32'(wr_viol), 32'd0);
`endif

        // Reset in the middle of a read
        @(negedge phi0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h123;
        @(posedge phi0);
        #2;
        chk("rd_strobes_active", 32'({CS_b, OE_b}), 32'b00);
        rst_b = 1'b0;
        #1;
        chk("async_reset_strobes", 32'({CS_b, WE_b, OE_b}), 32'b111);
        @(negedge phi0);
        cpu_req = 1'b0;
        @(negedge phi0);
        rst_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge phi0);
            chk_reset_vals("post_reset");
        end

        repeat (4) @(negedge phi0);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram6116_arb.md
# sram6116_arb

Two-port arbiter and access sequencer in front of the 6116 SRAM controller. It accepts level-held requests from a CPU port (read/write) and a video fetch port (read-only). It generates the registered A/Din/CS_b/WE_b/OE_b strobes consumed by the 6116 stage, captures that stage's registered Dout, and returns data with a one-cycle ack pulse. Video has priority, and a burst counter bounds CPU starvation.

## Interface
Parameters:
- ADDR_W, 11, SRAM address width (2K x 8)
- DATA_W, 8, data width
- VID_BURST, 4, max consecutive video grants while cpu_req is pending
- PROT_BASE, 11'h700, first write-protected address (used only with SRAM_ARB_WRPROT_EN)

Ports:
- phi0  in  1  system clock; all state updates on the rising edge
- rst_b  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU request, held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data; valid in the cpu_ack cycle, held until the next CPU read completes
- vid_req  in  1  video read request, held until vid_ack
- vid_addr  in  ADDR_W  video address
- vid_ack  out  1  one-cycle completion pulse
- vid_rdata  out  DATA_W  read data; valid in the vid_ack cycle, held until the next video read completes
- A  out  ADDR_W  SRAM address
- Din  out  DATA_W  SRAM write data
- Dout  in  DATA_W  SRAM read data; registered by the 6116 stage and high-Z when not driven
- CS_b, WE_b, OE_b  out  1  active-low SRAM strobes
- wr_viol  out  1  sticky write-protect violation flag

## Operation
- FSM states: IDLE, RD, RCAP, WR, ACK.
- IDLE arbitration, sampled at the phi0 edge:
  - If vid_req=1 and vid_run<VID_BURST (or cpu_req=0), grant video.
  - Otherwise, if cpu_req=1, grant CPU.
  - Otherwise, stay in IDLE.
- vid_run counter:
  - Increments on a video grant made while cpu_req=1.
  - Clears on any CPU grant, or on a video grant made while cpu_req=0.
  - Saturates at VID_BURST.
- Read grant (video, or CPU with cpu_we=0): go to RD. In RD, drive A=addr, CS_b=0, OE_b=0, WE_b=1.
- RD → RCAP: in RCAP, CS_b=OE_b=1. At the end of RCAP, Dout is latched into the granted port's rdata, that port's ack is set, and the FSM goes to ACK.
- Write grant (CPU with cpu_we=1): go to WR. In WR, drive A, Din=cpu_wdata, CS_b=0, WE_b=0, OE_b=1. At the end of WR, cpu_ack is set and the FSM goes to ACK.
- ACK: the ack pulse is high for exactly this cycle and no grant is made. The FSM then returns to IDLE.
  - A requester that keeps req high after its ack starts a new transaction.
- All SRAM-side outputs are registered. Strobes are asserted only in RD and WR.
- A and Din hold their last values outside active states.

## Timing
- Reset values: CS_b=WE_b=OE_b=1, A=0, Din=0, cpu_ack=vid_ack=0, cpu_rdata=vid_rdata=0, wr_viol=0, state IDLE, vid_run=0.
- Read: request sampled at edge E0; strobes active E0–E1; Dout valid E1–E2; captured at E2; ack high E2–E3.
  - Latency from the request-sampling edge to the ack rising edge is 2 cycles; ack occupies the 3rd cycle.
- Write: request sampled at E0; WE_b low E0–E1 (the 6116 writes at E1); ack high E1–E2.
- Minimum request spacing: reads 4 cycles, writes 3 cycles.
- A request arriving during RD/RCAP/WR/ACK waits for IDLE.
- Simultaneous cpu_req and vid_req follow the arbitration rule above. At most VID_BURST video grants occur before a pending CPU request is served.
- Reset mid-operation: strobes return high immediately (asynchronously). The transaction is dropped with no ack, and the requester must re-request.

## Configuration
- SRAM_ARB_WRPROT_EN defined:
  - A CPU write with cpu_addr>=PROT_BASE still runs through WR/ACK timing and cpu_ack pulses.
  - WE_b and CS_b stay high for that write.
  - wr_viol is set and remains set until reset.
- SRAM_ARB_WRPROT_EN undefined: all writes are performed and wr_viol is tied to 0.

## Test plan
- CPU write 0x5A to 0x123, then CPU read of 0x123 → WE_b low for exactly one cycle; cpu_ack 1 cycle after grant; read cpu_ack 2 cycles after grant with cpu_rdata=0x5A.
- vid_req and cpu_req both held high continuously, VID_BURST=4 → grant sequence V,V,V,V,C,V,V,V,V,C,…; no CPU wait exceeds 4 video transactions.
- Video read of 0x7FF preloaded with 0xC3 → vid_rdata=0xC3 in the vid_ack cycle; cpu_ack stays 0 and cpu_rdata is unchanged.
- rst_b asserted during RD → CS_b and OE_b go high within the same cycle; no ack; after release, outputs hold their reset values until a new request.
- With SRAM_ARB_WRPROT_EN: CPU write 0xFF to 0x700 → cpu_ack pulses, WE_b is never low, wr_viol=1, and a read of 0x700 returns its old value. Without the macro, the same write stores 0xFF and wr_viol stays 0.
- Back-to-back CPU reads with cpu_req held high → consecutive cpu_ack pulses exactly 4 cycles apart.
